// File: rtl/tiny_dnn_pkg.sv
// Shared types and widths for the tiny DNN address sequencer.
// TINY_DNN_SEQ_STAT_EN (optional) adds stall/beat statistics to tiny_dnn_seq.
package tiny_dnn_pkg;

  localparam int AW_DEF = 12;
  localparam int OC_W   = 4;
  localparam int DIM_W  = 5;
  localparam int STR_W  = 10;

  // Address tuple fields carried by every loop accumulator
  localparam int NF   = 3;
  localparam int F_IA = 0;
  localparam int F_WA = 1;
  localparam int F_OA = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tiny_dnn_seq_cnt.sv
// One loop level: wrapping counter plus a per-field address accumulator
// that steps by a stride on increment and reloads a base on wrap or clear.
module tiny_dnn_seq_cnt
  import tiny_dnn_pkg::*;
#(
  parameter int CW = DIM_W,
  parameter int AW = AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   inc,
  input  logic [CW-1:0]          limit,
  input  logic [NF-1:0][AW-1:0]  stride,
  input  logic [NF-1:0][AW-1:0]  base,
  output logic [CW-1:0]          cnt,
  output logic                   wrap,
  output logic [NF-1:0][AW-1:0]  acc
);

  assign wrap = inc && (cnt == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (clr || wrap) begin
      cnt <= '0;
      acc <= base;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
      for (int f = 0; f < NF; f++) begin
        acc[f] <= acc[f] + stride[f];
      end
    end
  end

endmodule

// File: rtl/tiny_dnn_seq.sv
// Convolution address sequencer: walks oc/oy/ox/ky/kx and emits ia/wa/oa tuples
// with valid/ready. Optional TINY_DNN_SEQ_STAT_EN adds stall_cnt and beat_cnt.
//
// state    | meaning
// ST_IDLE  | waiting for a run rising edge
// ST_RUN   | emitting address tuples
// ST_DRAIN | final tuple accepted, one settling cycle
// ST_DONE  | done pulse, then back to idle
module tiny_dnn_seq
  import tiny_dnn_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              run,
  input  logic [OC_W-1:0]   od,
  input  logic [DIM_W-1:0]  oh,
  input  logic [DIM_W-1:0]  ow,
  input  logic [DIM_W-1:0]  kh,
  input  logic [DIM_W-1:0]  kw,
  input  logic [STR_W-1:0]  ks,
  input  logic [STR_W-1:0]  os,
  input  logic [DIM_W-1:0]  iw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW-1:0]     ia,
  output logic [AW-1:0]     wa,
  output logic [AW-1:0]     oa,
  output logic              acc_first,
  output logic              acc_last,
  output logic              busy,
  output logic              done
`ifdef TINY_DNN_SEQ_STAT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       beat_cnt
`endif
);

  state_t state;
  logic   run_q;
  logic   start, clr, hs;

  logic [OC_W-1:0]  od_r;
  logic [DIM_W-1:0] oh_r, ow_r, kh_r, kw_r, iw_r;
  logic [STR_W-1:0] ks_r, os_r;

  logic [AW-1:0] pitch_i, pitch_k, pitch_o;
  logic [NF-1:0][AW-1:0] st_kx, st_ky, st_ox, st_oy, st_oc;
  logic [NF-1:0][AW-1:0] acc_kx, acc_ky, acc_ox, acc_oy, acc_oc;

  logic [DIM_W-1:0] cnt_kx, cnt_ky, cnt_ox_unused, cnt_oy_unused;
  logic [OC_W-1:0]  cnt_oc_unused;
  logic wrap_kx, wrap_ky, wrap_ox, wrap_oy, wrap_oc;

  assign start = run && !run_q;
  assign clr   = (state == ST_IDLE) && start;
  assign hs    = out_valid && out_ready;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state <= ST_IDLE;
      run_q <= 1'b0;
      od_r  <= '0;
      oh_r  <= '0;
      ow_r  <= '0;
      kh_r  <= '0;
      kw_r  <= '0;
      iw_r  <= '0;
      ks_r  <= '0;
      os_r  <= '0;
    end else begin
      run_q <= run;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            od_r  <= od;
            oh_r  <= oh;
            ow_r  <= ow;
            kh_r  <= kh;
            kw_r  <= kw;
            iw_r  <= iw;
            ks_r  <= ks;
            os_r  <= os;
          end
        end
        ST_RUN: begin
          if (!run)                state <= ST_IDLE;
          else if (hs && wrap_oc)  state <= ST_DRAIN;
        end
        ST_DRAIN: state <= run ? ST_DONE : ST_IDLE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Row pitches; each loop level contributes its own {oa, wa, ia} stride
  assign pitch_i = AW'(iw_r) + AW'(1);
  assign pitch_k = AW'(kw_r) + AW'(1);
  assign pitch_o = AW'(ow_r) + AW'(1);

  assign st_kx = {AW'(0),    AW'(1),    AW'(1)};
  assign st_ky = {AW'(0),    pitch_k,   pitch_i};
  assign st_ox = {AW'(1),    AW'(0),    AW'(1)};
  assign st_oy = {pitch_o,   AW'(0),    pitch_i};
  assign st_oc = {AW'(os_r), AW'(ks_r), AW'(0)};

  tiny_dnn_seq_cnt #(.CW(DIM_W), .AW(AW)) u_kx (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(clr), .inc(hs),
    .limit(kw_r), .stride(st_kx), .base('0),
    .cnt(cnt_kx), .wrap(wrap_kx), .acc(acc_kx));

  tiny_dnn_seq_cnt #(.CW(DIM_W), .AW(AW)) u_ky (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(clr), .inc(wrap_kx),
    .limit(kh_r), .stride(st_ky), .base('0),
    .cnt(cnt_ky), .wrap(wrap_ky), .acc(acc_ky));

  tiny_dnn_seq_cnt #(.CW(DIM_W), .AW(AW)) u_ox (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(clr), .inc(wrap_ky),
    .limit(ow_r), .stride(st_ox), .base('0),
    .cnt(cnt_ox_unused), .wrap(wrap_ox), .acc(acc_ox));

  tiny_dnn_seq_cnt #(.CW(DIM_W), .AW(AW)) u_oy (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(clr), .inc(wrap_ox),
    .limit(oh_r), .stride(st_oy), .base('0),
    .cnt(cnt_oy_unused), .wrap(wrap_oy), .acc(acc_oy));

  tiny_dnn_seq_cnt #(.CW(OC_W), .AW(AW)) u_oc (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .clr(clr), .inc(wrap_oy),
    .limit(od_r), .stride(st_oc), .base('0),
    .cnt(cnt_oc_unused), .wrap(wrap_oc), .acc(acc_oc));

  assign ia = acc_kx[F_IA] + acc_ky[F_IA] + acc_ox[F_IA] + acc_oy[F_IA] + acc_oc[F_IA];
  assign wa = acc_kx[F_WA] + acc_ky[F_WA] + acc_ox[F_WA] + acc_oy[F_WA] + acc_oc[F_WA];
  assign oa = acc_kx[F_OA] + acc_ky[F_OA] + acc_ox[F_OA] + acc_oy[F_OA] + acc_oc[F_OA];

  assign out_valid = (state == ST_RUN);
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign acc_first = out_valid && (cnt_kx == '0) && (cnt_ky == '0);
  assign acc_last  = out_valid && (cnt_kx == kw_r) && (cnt_ky == kh_r);

`ifdef TINY_DNN_SEQ_STAT_EN
  // Counters only move in RUN, so they hold their totals after DONE
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      stall_cnt <= '0;
      beat_cnt  <= '0;
    end else if (clr) begin
      stall_cnt <= '0;
      beat_cnt  <= '0;
    end else if (state == ST_RUN) begin
      if (hs)         beat_cnt  <= sat_inc(beat_cnt);
      if (!out_ready) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule
